// File: rtl/ff2_sync.sv
// Multi-flop CDC synchroniser with rise/fall edge pulses on the synchronised value.
// One instance per crossing flag; active edge selected by NEGEDGE.
module ff2_sync #(
  parameter int unsigned       WIDTH       = 1,
  parameter int unsigned       STAGES      = 2,
  parameter bit                NEGEDGE     = 1'b0,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("ff2_sync: STAGES must be in 2..4");
  end

  // s[0] is the metastability-exposed capture flop; keep the chain intact.
  (* ASYNC_REG = "TRUE", keep = "true" *)
  logic [STAGES-1:0][WIDTH-1:0] s;
  logic [WIDTH-1:0]             h;

  if (NEGEDGE) begin : g_neg
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s <= {STAGES{RESET_VALUE}};
        h <= RESET_VALUE;
      end else begin
        s <= {s[STAGES-2:0], d};
        h <= s[STAGES-1];
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s <= {STAGES{RESET_VALUE}};
        h <= RESET_VALUE;
      end else begin
        s <= {s[STAGES-2:0], d};
        h <= s[STAGES-1];
      end
    end
  end

  assign q    = s[STAGES-1];
  assign rise = q & ~h;
  assign fall = ~q & h;

endmodule

// File: tb/tb_ff2_sync.sv
// Self-checking bench for ff2_sync: posedge, negedge, 3-stage and 4-bit instances.
module tb_ff2_sync;

  logic       clk;
  logic       rst_n;
  logic       d_p, q_p, r_p, f_p;
  logic       d_n, q_n, r_n, f_n;
  logic       d_3, q_3, r_3, f_3;
  logic [3:0] d_w, q_w, r_w, f_w;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         sel;
    logic [3:0] d, q, r, f;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    logic [3:0] q, r, f;
  } exp_t;
  exp_t sb[$];

  ff2_sync #(.WIDTH(1), .STAGES(2), .NEGEDGE(1'b0), .RESET_VALUE(1'b0)) u_p (
    .clk(clk), .rst_n(rst_n), .d(d_p), .q(q_p), .rise(r_p), .fall(f_p));
  ff2_sync #(.WIDTH(1), .STAGES(2), .NEGEDGE(1'b1), .RESET_VALUE(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .d(d_n), .q(q_n), .rise(r_n), .fall(f_n));
  ff2_sync #(.WIDTH(1), .STAGES(3), .NEGEDGE(1'b0), .RESET_VALUE(1'b0)) u_3 (
    .clk(clk), .rst_n(rst_n), .d(d_3), .q(q_3), .rise(r_3), .fall(f_3));
  ff2_sync #(.WIDTH(4), .STAGES(2), .NEGEDGE(1'b0), .RESET_VALUE(4'b1010)) u_w (
    .clk(clk), .rst_n(rst_n), .d(d_w), .q(q_w), .rise(r_w), .fall(f_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int sel, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s sel=%0d t=%0t actual=%b required=%b", nm, sel, $time, act, exp);
    end
  endtask

  task automatic set_d(input int sel, input logic [3:0] v);
    case (sel)
      0: d_p = v[0];
      1: d_n = v[0];
      2: d_3 = v[0];
      default: d_w = v;
    endcase
  endtask

  task automatic push_exp(input logic [3:0] q, input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.q = q; e.r = r; e.f = f;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int sel);
    exp_t e;
    logic [3:0] aq, ar, af;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty sel=%0d actual=0 required=1", sel);
      return;
    end
    e = sb.pop_front();
    case (sel)
      0: begin aq = {3'b0, q_p}; ar = {3'b0, r_p}; af = {3'b0, f_p}; end
      1: begin aq = {3'b0, q_n}; ar = {3'b0, r_n}; af = {3'b0, f_n}; end
      2: begin aq = {3'b0, q_3}; ar = {3'b0, r_3}; af = {3'b0, f_3}; end
      default: begin aq = q_w; ar = r_w; af = f_w; end
    endcase
    chk("q", sel, aq, e.q);
    chk("rise", sel, ar, e.r);
    chk("fall", sel, af, e.f);
  endtask

  // Drive at the inactive edge region, check after the active edge and again after
  // the following inactive edge (outputs must not move there).
  task automatic apply(input int sel, input logic [3:0] d, input logic [3:0] q,
                       input logic [3:0] r, input logic [3:0] f);
    set_d(sel, d);
    push_exp(q, r, f);
    push_exp(q, r, f);
    if (sel == 1) begin
      @(negedge clk); #1 pop_cmp(sel);
      @(posedge clk); #1 pop_cmp(sel);
    end else begin
      @(posedge clk); #1 pop_cmp(sel);
      @(negedge clk); #1 pop_cmp(sel);
    end
  endtask

  task automatic do_reset(input int sel, input logic [3:0] dval);
    logic [3:0] rv;
    rv = (sel == 3) ? 4'b1010 : 4'b0000;
    set_d(sel, dval);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp(rv, 4'b0, 4'b0);
      @(posedge clk); #1 pop_cmp(sel);
    end
    if (sel == 1) begin
      @(posedge clk); #1;
    end else begin
      @(negedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic run_seg(input int sel);
    foreach (vecs[i])
      if (vecs[i].sel == sel)
        apply(sel, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].f);
  endtask

  function automatic void add(input int sel, input logic [3:0] d, input logic [3:0] q,
                              input logic [3:0] r, input logic [3:0] f);
    vec_t v;
    v.sel = sel; v.d = d; v.q = q; v.r = r; v.f = f;
    vecs.push_back(v);
  endfunction

  initial begin
    rst_n = 1'b0;
    d_p = 1'b0; d_n = 1'b0; d_3 = 1'b0; d_w = 4'b0000;

    // posedge, 2 stages; d held 1 through reset
    add(0, 1, 0, 0, 0); add(0, 1, 1, 1, 0); add(0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0); add(0, 0, 0, 0, 1); add(0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0); add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 0);
    // negedge, 2 stages
    add(1, 1, 0, 0, 0); add(1, 1, 1, 1, 0); add(1, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0); add(1, 0, 0, 0, 1); add(1, 0, 0, 0, 0);
    // 3 stages
    add(2, 1, 0, 0, 0); add(2, 1, 0, 0, 0); add(2, 1, 1, 1, 0);
    add(2, 1, 1, 0, 0); add(2, 0, 1, 0, 0); add(2, 0, 1, 0, 0);
    add(2, 0, 0, 0, 1); add(2, 0, 0, 0, 0);
    // 4-bit, reset value 1010
    add(3, 4'b0101, 4'b1010, 4'b0000, 4'b0000);
    add(3, 4'b0101, 4'b0101, 4'b0101, 4'b1010);
    add(3, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
    add(3, 4'b1111, 4'b0101, 4'b0000, 4'b0000);
    add(3, 4'b1111, 4'b1111, 4'b1010, 4'b0000);
    add(3, 4'b1111, 4'b1111, 4'b0000, 4'b0000);

    do_reset(0, 4'b0001);    run_seg(0);
    do_reset(1, 4'b0000);    run_seg(1);
    do_reset(2, 4'b0000);    run_seg(2);
    do_reset(3, 4'b0101);    run_seg(3);

    // async reset while a 1 sits in s[0]
    do_reset(0, 4'b0000);
    set_d(0, 4'b0001);
    push_exp(0, 0, 0);
    @(posedge clk); #1 pop_cmp(0);
    #1 rst_n = 1'b0;
    push_exp(0, 0, 0);
    #1 pop_cmp(0);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    apply(0, 1, 0, 0, 0);
    apply(0, 1, 1, 1, 0);
    apply(0, 1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
